// File: rtl/prog_state_machine_if.sv
// Bus bundle for prog_state_machine: step/input/config controls in, state observation out.
// The controller drives i_* through the master modport; the FSM drives o_* through the slave modport.
interface prog_state_machine_if #(
   parameter int NUM_STATES = 5,
   parameter int STATE_W    = 3,
   parameter int IN_W       = 1,
   parameter int OUT_W      = 1,
   parameter int CNT_W      = 8
);
   logic                  i_step;
   logic [IN_W-1:0]       i_in;
   logic                  i_sync_clr;
   logic                  i_clr_err;
   logic                  i_cfg_we;
   logic [STATE_W-1:0]    i_cfg_state;
   logic [IN_W-1:0]       i_cfg_sym;
   logic [STATE_W-1:0]    i_cfg_next;
   logic                  i_cfg_out_we;
   logic [OUT_W-1:0]      i_cfg_out;
   logic [NUM_STATES-1:0] o_state_oh;
   logic [STATE_W-1:0]    o_state_idx;
   logic [OUT_W-1:0]      o_out;
   logic                  o_err;
   logic [CNT_W-1:0]      o_step_cnt;

   modport master (
      output i_step, i_in, i_sync_clr, i_clr_err,
             i_cfg_we, i_cfg_state, i_cfg_sym, i_cfg_next, i_cfg_out_we, i_cfg_out,
      input  o_state_oh, o_state_idx, o_out, o_err, o_step_cnt
   );

   modport slave (
      input  i_step, i_in, i_sync_clr, i_clr_err,
             i_cfg_we, i_cfg_state, i_cfg_sym, i_cfg_next, i_cfg_out_we, i_cfg_out,
      output o_state_oh, o_state_idx, o_out, o_err, o_step_cnt
   );
endinterface

// File: rtl/prog_state_machine.sv
// Run-time programmable Moore FSM: next-state and output tables live in flops and are
// written through config ports; adds step enable, illegal-transition flag and step counter.
module prog_state_machine #(
   parameter int NUM_STATES  = 5,
   parameter int STATE_W     = 3,
   parameter int IN_W        = 1,
   parameter int OUT_W       = 1,
   parameter int RESET_STATE = 0,
   parameter int CNT_W       = 8
) (
   input logic                  i_flux,
   input logic                  i_reset,
   prog_state_machine_if.slave  bus
);
   localparam int SYMS    = 2**IN_W;
   localparam int ENTRIES = NUM_STATES * SYMS;
   localparam int AW      = STATE_W + IN_W;
   localparam logic [STATE_W-1:0] RST_IDX = STATE_W'(RESET_STATE);

   typedef logic [STATE_W-1:0] state_t;

   state_t             r_next_tbl [ENTRIES];
   logic [OUT_W-1:0]   r_out_tbl  [NUM_STATES];
   state_t             r_state;
   logic               r_err;
   logic [CNT_W-1:0]   r_cnt;

   logic [AW-1:0]      w_rd_addr;
   logic [AW-1:0]      w_wr_addr;
   state_t             w_nxt;
   logic               w_nxt_legal;
   logic               w_cfg_ok;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Symbol count is a power of two, so {state, sym} is the row-major entry index.
   assign w_rd_addr   = {r_state, bus.i_in};
   assign w_wr_addr   = {bus.i_cfg_state, bus.i_cfg_sym};
   assign w_nxt       = r_next_tbl[w_rd_addr];
   assign w_nxt_legal = int'(w_nxt) < NUM_STATES;
   assign w_cfg_ok    = int'(bus.i_cfg_state) < NUM_STATES;

   always_ff @(posedge i_flux or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= RST_IDX;
         r_err   <= 1'b0;
         r_cnt   <= '0;
         for (int i = 0; i < ENTRIES; i++) r_next_tbl[i] <= RST_IDX;
         for (int s = 0; s < NUM_STATES; s++) r_out_tbl[s] <= '0;
      end else begin
         // Table writes and the step read share the edge, so a step sees the old contents.
         if (w_cfg_ok && bus.i_cfg_we)     r_next_tbl[w_wr_addr]     <= bus.i_cfg_next;
         if (w_cfg_ok && bus.i_cfg_out_we) r_out_tbl[bus.i_cfg_state] <= bus.i_cfg_out;

         if (bus.i_clr_err) r_err <= 1'b0;

         if (bus.i_sync_clr) begin
            r_state <= RST_IDX;
            r_cnt   <= '0;
         end else if (bus.i_step) begin
            r_cnt <= sat_inc(r_cnt);
            if (w_nxt_legal) begin
               r_state <= w_nxt;
            end else begin
               r_state <= RST_IDX;
               r_err   <= 1'b1;
            end
         end
      end
   end

   assign bus.o_state_idx = r_state;
   assign bus.o_state_oh  = NUM_STATES'(1) << r_state;
   assign bus.o_out       = r_out_tbl[r_state];
   assign bus.o_err       = r_err;
   assign bus.o_step_cnt  = r_cnt;
endmodule

// File: tb/tb_prog_state_machine.sv
// Directed bench for prog_state_machine: default build plus a CNT_W=3 / IN_W=2 variant.
module tb_prog_state_machine;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   prog_state_machine_if                           bif();
   prog_state_machine_if #(.IN_W(2), .CNT_W(3))    vif();

   prog_state_machine u_dut (
      .i_flux  (clk),
      .i_reset (rst_n),
      .bus     (bif)
   );

   prog_state_machine #(.IN_W(2), .CNT_W(3)) u_var (
      .i_flux  (clk),
      .i_reset (rst_n),
      .bus     (vif)
   );

   typedef struct {
      bit step;
      int in;
      int idx;
      int out;
      int cnt;
   } vec_t;

   vec_t walk[10];
   int   diag[5][2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string n, input int idx, input int o, input int e, input int c);
      chk({n, ".idx"}, 32'(bif.o_state_idx), idx);
      chk({n, ".oh"},  32'(bif.o_state_oh),  32'(1) << idx);
      chk({n, ".out"}, 32'(bif.o_out),       o);
      chk({n, ".err"}, 32'(bif.o_err),       e);
      chk({n, ".cnt"}, 32'(bif.o_step_cnt),  c);
   endtask

   task automatic wr_next(input int s, input int sym, input int nx);
      bif.i_cfg_we    = 1'b1;
      bif.i_cfg_state = 3'(s);
      bif.i_cfg_sym   = 1'(sym);
      bif.i_cfg_next  = 3'(nx);
      tick();
      bif.i_cfg_we    = 1'b0;
   endtask

   task automatic wr_out(input int s, input int v);
      bif.i_cfg_out_we = 1'b1;
      bif.i_cfg_state  = 3'(s);
      bif.i_cfg_out    = 1'(v);
      tick();
      bif.i_cfg_out_we = 1'b0;
   endtask

   task automatic step(input int sym);
      bif.i_step = 1'b1;
      bif.i_in   = 1'(sym);
      tick();
      bif.i_step = 1'b0;
      bif.i_in   = 'x;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      diag = '{'{1, 2}, '{1, 3}, '{4, 2}, '{4, 2}, '{1, 3}};
      walk[0] = '{1, 1, 2, 0, 1};
      walk[1] = '{1, 0, 4, 1, 2};
      walk[2] = '{1, 1, 3, 0, 3};
      walk[3] = '{1, 0, 4, 1, 4};
      walk[4] = '{1, 0, 1, 0, 5};
      walk[5] = '{1, 0, 1, 0, 6};
      walk[6] = '{1, 1, 3, 0, 7};
      walk[7] = '{1, 1, 2, 0, 8};
      walk[8] = '{1, 1, 2, 0, 9};
      walk[9] = '{0, 0, 2, 0, 9};

      {bif.i_step, bif.i_in, bif.i_sync_clr, bif.i_clr_err, bif.i_cfg_we, bif.i_cfg_state,
       bif.i_cfg_sym, bif.i_cfg_next, bif.i_cfg_out_we, bif.i_cfg_out} = '0;
      {vif.i_step, vif.i_in, vif.i_sync_clr, vif.i_clr_err, vif.i_cfg_we, vif.i_cfg_state,
       vif.i_cfg_sym, vif.i_cfg_next, vif.i_cfg_out_we, vif.i_cfg_out} = '0;

      // Reset held while stepping
      rst_n      = 1'b0;
      bif.i_step = 1'b1;
      repeat (3) tick();
      chk_all("reset", 0, 0, 0, 0);
      bif.i_step = 1'b0;
      rst_n      = 1'b1;
      tick();

      // Team diagram: A..E = 0..4, only E outputs 1
      for (int s = 0; s < 5; s++)
         for (int b = 0; b < 2; b++) wr_next(s, b, diag[s][b]);
      wr_out(4, 1);
      chk_all("prog", 0, 0, 0, 0);

      for (int i = 0; i < 10; i++) begin
         bif.i_step = walk[i].step;
         bif.i_in   = walk[i].step ? 1'(walk[i].in) : 1'bx;
         tick();
         chk_all($sformatf("walk%0d", i), walk[i].idx, walk[i].out, 0, walk[i].cnt);
      end
      bif.i_step = 1'b0;

      // Illegal transition, clr_err vs set, sync_clr keeps err
      wr_next(2, 1, 7);
      step(1);
      chk_all("illegal", 0, 0, 1, 10);
      step(1);
      chk_all("to_c", 2, 0, 1, 11);
      bif.i_clr_err = 1'b1;
      step(1);
      bif.i_clr_err = 1'b0;
      chk_all("clr_vs_set", 0, 0, 1, 12);
      bif.i_sync_clr = 1'b1;
      tick();
      bif.i_sync_clr = 1'b0;
      chk_all("sclr_keep_err", 0, 0, 1, 0);
      bif.i_clr_err = 1'b1;
      tick();
      bif.i_clr_err = 1'b0;
      chk_all("clr_err", 0, 0, 0, 0);

      // Read-before-write on the same edge
      bif.i_cfg_we    = 1'b1;
      bif.i_cfg_state = 3'd0;
      bif.i_cfg_sym   = 1'b0;
      bif.i_cfg_next  = 3'd3;
      step(0);
      bif.i_cfg_we    = 1'b0;
      chk_all("rbw", 1, 0, 0, 1);
      bif.i_sync_clr = 1'b1;
      tick();
      bif.i_sync_clr = 1'b0;
      step(0);
      chk_all("new_tbl", 3, 0, 0, 1);

      // Asynchronous reset between edges
      rst_n = 1'b0;
      #2;
      chk_all("async_rst", 0, 0, 0, 0);
      rst_n = 1'b1;
      step(0);
      chk_all("tbl_cleared", 0, 0, 0, 1);

      // sync_clr priority over step, tables kept
      wr_next(0, 0, 3);
      wr_out(3, 1);
      step(0);
      chk_all("to_d", 3, 1, 0, 2);
      bif.i_sync_clr = 1'b1;
      step(0);
      bif.i_sync_clr = 1'b0;
      chk_all("sclr_prio", 0, 0, 0, 0);
      step(0);
      chk_all("sclr_keep_tbl", 3, 1, 0, 1);
      wr_out(3, 0);
      chk_all("out_wr", 3, 0, 0, 1);
      wr_out(5, 1);
      wr_next(5, 0, 1);
      chk_all("oob_wr", 3, 0, 0, 1);

      // Both config writes on one edge
      bif.i_cfg_we     = 1'b1;
      bif.i_cfg_out_we = 1'b1;
      bif.i_cfg_state  = 3'd3;
      bif.i_cfg_sym    = 1'b1;
      bif.i_cfg_next   = 3'd4;
      bif.i_cfg_out    = 1'b1;
      tick();
      bif.i_cfg_we     = 1'b0;
      bif.i_cfg_out_we = 1'b0;
      chk_all("dual_wr", 3, 1, 0, 1);
      step(1);
      chk_all("dual_step", 4, 0, 0, 2);

      // Width variant: four symbols from state 0
      for (int s = 0; s < 4; s++) begin
         vif.i_cfg_we    = 1'b1;
         vif.i_cfg_state = 3'd0;
         vif.i_cfg_sym   = 2'(s);
         vif.i_cfg_next  = 3'(s + 1);
         tick();
      end
      vif.i_cfg_we = 1'b0;
      for (int s = 0; s < 4; s++) begin
         vif.i_sync_clr = 1'b1;
         tick();
         vif.i_sync_clr = 1'b0;
         vif.i_step     = 1'b1;
         vif.i_in       = 2'(s);
         tick();
         vif.i_step     = 1'b0;
         chk($sformatf("var_sym%0d.idx", s), 32'(vif.o_state_idx), s + 1);
         chk($sformatf("var_sym%0d.oh", s),  32'(vif.o_state_oh),  32'(1) << (s + 1));
         chk($sformatf("var_sym%0d.cnt", s), 32'(vif.o_step_cnt),  1);
      end

      // Width variant: counter saturation
      vif.i_sync_clr = 1'b1;
      tick();
      vif.i_sync_clr = 1'b0;
      chk("var_clr.cnt", 32'(vif.o_step_cnt), 0);
      for (int k = 1; k <= 10; k++) begin
         vif.i_step = 1'b1;
         vif.i_in   = 2'd0;
         tick();
         chk($sformatf("var_sat%0d", k), 32'(vif.o_step_cnt), (k > 7) ? 7 : k);
      end
      vif.i_step = 1'b0;
      chk("var_err", 32'(vif.o_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/prog_state_machine.md
Name: prog_state_machine

Overview:
Run-time programmable Moore finite-state machine: the parametrised successor of the team's fixed five-state diagram FSM.
- Next-state table indexed by {current state, input symbol} is written through a config port.
- Per-state output table is written through a second config port.
- Adds step enable, multi-bit input symbols, illegal-transition detection and a saturating step counter.
- Sits between the stimulus/controller logic and any consumer of the one-hot state or output.

Parameters:
NUM_STATES, 5, number of legal states (2..2**STATE_W)
STATE_W, 3, state index width
IN_W, 1, input symbol width; each state has 2**IN_W table entries
OUT_W, 1, per-state Moore output width
RESET_STATE, 0, state index entered on reset, sync_clr or illegal transition
CNT_W, 8, step counter width

Ports:
flux  in  1  clock, rising-edge active
reset  in  1  asynchronous, active-low; 0 = in reset
step  in  1  advance FSM on this edge
in  in  IN_W  input symbol, sampled when step=1
sync_clr  in  1  synchronous return to RESET_STATE; tables kept
clr_err  in  1  synchronous clear of err
cfg_we  in  1  write next-state entry
cfg_state  in  STATE_W  entry row (current state)
cfg_sym  in  IN_W  entry column (input symbol)
cfg_next  in  STATE_W  next-state value written
cfg_out_we  in  1  write output table entry for cfg_state
cfg_out  in  OUT_W  output value written
state_oh  out  NUM_STATES  one-hot current state
state_idx  out  STATE_W  binary current state
out  out  OUT_W  Moore output: out_table[state_idx]
err  out  1  sticky illegal-transition flag
step_cnt  out  CNT_W  saturating count of steps taken

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - state_idx=RESET_STATE; state_oh has only bit RESET_STATE set.
  - All next-state entries = RESET_STATE; all output entries = 0, so out=0.
  - err=0; step_cnt=0.
- Reset asserted mid-operation overrides everything in progress. Operation resumes on the first rising edge after reset=1.
- Step: on a rising edge with step=1, nxt = table[state_idx][in].
  - If nxt < NUM_STATES: state_idx <= nxt.
  - Otherwise: state_idx <= RESET_STATE and err <= 1.
  - step=0: state holds; in is ignored (may be X).
  - Latency is one edge: state_oh, state_idx and out reflect the new state right after the edge.
- out is combinational from the state register and output table; no extra latency.
- step_cnt increments on every step=1 edge, including illegal ones. It saturates at 2**CNT_W-1 (no wrap).
- sync_clr=1 at an edge:
  - state_idx <= RESET_STATE; step_cnt <= 0.
  - Tables and err are unchanged.
  - Has priority over step on the same edge.
- clr_err=1 clears err at the edge. If an illegal step happens on the same edge, set wins and err=1.
- Config writes take effect at the edge.
  - A step on the same edge uses the old table contents (read-before-write).
  - An output write to the current state changes out after that edge.
  - Writes with cfg_state >= NUM_STATES are ignored.
  - cfg_we and cfg_out_we may both be asserted together.
- Table storage: NUM_STATES*2**IN_W entries of STATE_W bits, plus NUM_STATES entries of OUT_W bits, in flops. No unknowns are allowed after reset.
- state_oh is always exactly one-hot; state_idx is never >= NUM_STATES.

Test Plan:
- Reset values: hold reset=0, run 3 edges with step=1 -> state_idx=0, state_oh=5'b00001, out=0, err=0, step_cnt=0.
- Program the team diagram, with A..E = 0..4, only E's output = 1:
  - Transitions: A:0->B, 1->C; B:0->B, 1->D; C:0->E, 1->C; D:0->E, 1->C; E:0->B, 1->D.
  - Step with in = 1,0,1,0,0,0,1,1,1 -> states C,E,D,E,B,B,D,C,C.
  - out = 1 only after the edges landing in E; step_cnt=9.
- Illegal transition and same-edge priority:
  - Write table[2][1]=7, then step from C with in=1 -> state_idx=0, err=1.
  - Assert clr_err on an edge with a second illegal step -> err stays 1.
  - Assert clr_err with step=0 -> err=0.
- Read-before-write: on one edge write table[0][0]=3 and step from A with in=0 -> B; reset reloads table, redo -> first step B; repeat write then step on next edge -> D.
- Async reset mid-run: after reaching D, pull reset low between edges -> state_oh=00001 immediately, table cleared, step_cnt=0. sync_clr from D -> A with table kept.
- Saturation and width variant (CNT_W=3, IN_W=2):
  - 10 steps -> step_cnt=7 and holds.
  - Four distinct symbols from state 0 (table entries 1,2,3,4) reach 1,2,3,4 respectively.
